adapter_bus_arbiter: RTL and testbench
======================================

// Module: adapter_bus_arbiter
// PURPOSE
//  Shares one width-to-bus adapter (PipeInLength in, PipeInLast out) among NREQ requesters.
//  Round-robin grant; the grant is held until the adapter emits the message's last beat.
//  owner/owner_vld tag every outgoing beat with its source.
//  Sits between the NREQ message producers and the single adapter instance.
// PARAMETERS
//  NREQ   4    number of requesters, 2..16
//  width  128  message data width; equals the adapter's width
//  IDW    $clog2(NREQ)  owner index width; derived, do not override
// PORTS
//  CLK            in   1           clock
//  nRST           in   1           asynchronous active-low reset
//  req_pend       in   NREQ        requester i has a message waiting
//  req_enq__ENA   in   NREQ        requester i enq; legal only while req_enq__RDY[i]
//  req_enq__RDY   out  NREQ        enq accept, one-hot or zero
//  req_enq_v      in   NREQ*width  message data, slice i = [i*width +: width]
//  req_enq_size   in   NREQ*16     message length in bits, slice i = [i*16 +: 16]
//  ad_enq__ENA    out  1           enq to adapter
//  ad_enq__RDY    in   1           adapter idle (remain==0)
//  ad_enq_v       out  width       data to adapter
//  ad_enq_size    out  16          length to adapter
//  ad_last_beat   in   1           adapter out.enq__ENA & out.enq__RDY & out.enq$last
//  owner          out  IDW         current grant index
//  owner_vld      out  1           grant held (ISSUE or DRAIN)
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, rr_ptr=0, owner=0, owner_vld=0.
//   All RDY/ENA outputs 0; ad_enq_v=0; ad_enq_size=0.
//  IDLE: if any req_pend, pick the first set bit at or after rr_ptr (modulo NREQ).
//   owner<=pick; go to ISSUE next cycle. This gives 1 cycle from req_pend to RDY offer.
//  ISSUE: req_enq__RDY[owner] = ad_enq__RDY; all other RDY bits 0.
//   ad_enq__ENA = req_enq__ENA[owner] & ad_enq__RDY.
//   ad_enq_v and ad_enq_size are the owner's slices while ENA is high, else 0.
//   On handshake: if size==0, go to IDLE (adapter emits no beats); else go to DRAIN.
//   If req_pend[owner] drops in ISSUE before handshake, go to IDLE and advance rr_ptr (request withdrawn).
//  DRAIN: all req RDY 0, ad_enq__ENA 0. On ad_last_beat: go to IDLE, rr_ptr<=owner+1 (wraps NREQ-1 -> 0).
//  owner_vld=1 in ISSUE and DRAIN; owner is stable through both states.
//  Combinational paths:
//   req_enq__ENA -> ad_enq__ENA is combinational, with no added cycle of latency.
//   ad_enq__RDY -> req_enq__RDY is combinational.
//  Simultaneous events:
//   ad_last_beat and new req_pend in the same cycle: IDLE next cycle, grant the cycle after.
//   There is no back-to-back skip.
//   ad_last_beat outside DRAIN is ignored. req_enq__ENA without the matching RDY is ignored.
//  Only one message is ever in flight in the adapter, so beats cannot interleave between owners.
//  Reset mid-message: arbiter state clears immediately. Adapter reset is the integrator's responsibility.
//  Fairness: each requester is granted within NREQ-1 other messages.
// CONFIGURATION
//  ADAPTER_ARB_STATS_EN defined:
//   Adds input stat_sel [IDW] and output stat_cnt [32].
//   Per-requester 32-bit message counter increments on each ISSUE handshake; it saturates at 2^32-1.
//   Counters reset to 0. stat_cnt = count[stat_sel], combinational read.
//  ADAPTER_ARB_STATS_EN undefined: these ports and counters do not exist; all other behaviour is identical.
// TESTING
//  T1 single: req_pend=4'b0010, size=96, width=128, owidth=32.
//     -> RDY[1] one cycle later, owner=1, 3 beats out, IDLE after the last beat.
//  T2 round-robin: all four pend continuously, each size=32.
//     -> grant order 0,1,2,3,0; no RDY overlap; owner_vld drops 1 cycle between grants.
//  T3 backpressure: ad_enq__RDY=0 for 5 cycles in ISSUE.
//     -> req_enq__RDY[owner]=0 for those cycles; no ad_enq__ENA; no state change.
//  T4 zero size: requester 2 sends size=0.
//     -> handshake, IDLE next cycle, no DRAIN, rr_ptr=3.
//  T5 withdraw + reset: req_pend[0] drops in ISSUE -> IDLE, next grant goes to 1.
//     nRST asserted mid-DRAIN -> outputs 0 with no clock edge.
//  T6 stats (ADAPTER_ARB_STATS_EN): 3 messages from requester 1, stat_sel=1 -> stat_cnt=3; stat_sel=0 -> 0.

Source files
------------

// File: rtl/adapter_bus_arbiter.sv
// Round-robin arbiter sharing one width-to-bus adapter among NREQ message producers.
// Optional per-requester message counters are enabled with `define ADAPTER_ARB_STATS_EN.
module adapter_bus_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned width = 128,
  localparam int unsigned IDW  = $clog2(NREQ)
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic [NREQ-1:0]         req_pend,
  input  logic [NREQ-1:0]         req_enq__ENA,
  output logic [NREQ-1:0]         req_enq__RDY,
  input  logic [NREQ*width-1:0]   req_enq_v,
  input  logic [NREQ*16-1:0]      req_enq_size,
  output logic                    ad_enq__ENA,
  input  logic                    ad_enq__RDY,
  output logic [width-1:0]        ad_enq_v,
  output logic [15:0]             ad_enq_size,
  input  logic                    ad_last_beat,
  output logic [IDW-1:0]          owner,
  output logic                    owner_vld
`ifdef ADAPTER_ARB_STATS_EN
  ,
  input  logic [IDW-1:0]          stat_sel,
  output logic [31:0]             stat_cnt
`endif
);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} arbState_e;

  arbState_e        stateQ, stateD;
  logic [IDW-1:0]   ownerQ, ownerD;
  logic [IDW-1:0]   rrPtrQ, rrPtrD;
  logic [IDW-1:0]   pick;
  logic [IDW-1:0]   scanIdx;
  logic [IDW-1:0]   ownerInc;
  logic             anyPend;
  logic             ownerPend;
  logic             ownerEna;
  logic [width-1:0] ownerData;
  logic [15:0]      ownerSize;
  logic             handshake;

  // Scan downward so the candidate closest to rrPtrQ is the last one written.
  always_comb begin
    anyPend = 1'b0;
    pick    = '0;
    scanIdx = '0;
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      scanIdx = IDW'((int'(rrPtrQ) + k) % int'(NREQ));
      for (int i = 0; i < int'(NREQ); i++) begin
        if (scanIdx == IDW'(i) && req_pend[i]) begin
          pick    = IDW'(i);
          anyPend = 1'b1;
        end
      end
    end
  end

  always_comb begin
    ownerPend = 1'b0;
    ownerEna  = 1'b0;
    ownerData = '0;
    ownerSize = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (ownerQ == IDW'(i)) begin
        ownerPend = req_pend[i];
        ownerEna  = req_enq__ENA[i];
        ownerData = req_enq_v[i*width +: width];
        ownerSize = req_enq_size[i*16 +: 16];
      end
    end
  end

  always_comb begin
    req_enq__RDY = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      req_enq__RDY[i] = (stateQ == StIssue) && (ownerQ == IDW'(i)) && ad_enq__RDY;
    end
  end

  assign handshake = (stateQ == StIssue) && ownerEna && ad_enq__RDY;
  assign ownerInc  = (ownerQ == IDW'(NREQ - 1)) ? '0 : ownerQ + 1'b1;

  always_comb begin
    stateD      = stateQ;
    ownerD      = ownerQ;
    rrPtrD      = rrPtrQ;
    ad_enq__ENA = 1'b0;
    ad_enq_v    = '0;
    ad_enq_size = '0;
    unique case (stateQ)
      StIdle: begin
        if (anyPend) begin
          ownerD = pick;
          stateD = StIssue;
        end
      end
      StIssue: begin
        ad_enq__ENA = handshake;
        if (handshake) begin
          ad_enq_v    = ownerData;
          ad_enq_size = ownerSize;
          // A zero-length message produces no beats, so there is nothing to drain.
          if (ownerSize == 16'd0) begin
            stateD = StIdle;
            rrPtrD = ownerInc;
          end else begin
            stateD = StDrain;
          end
        end else if (!ownerPend) begin
          stateD = StIdle;
          rrPtrD = ownerInc;
        end
      end
      StDrain: begin
        if (ad_last_beat) begin
          stateD = StIdle;
          rrPtrD = ownerInc;
        end
      end
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stateQ <= StIdle;
      ownerQ <= '0;
      rrPtrQ <= '0;
    end else begin
      stateQ <= stateD;
      ownerQ <= ownerD;
      rrPtrQ <= rrPtrD;
    end
  end

  assign owner     = ownerQ;
  assign owner_vld = (stateQ != StIdle);

`ifdef ADAPTER_ARB_STATS_EN
  logic [31:0] statCntQ [NREQ];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < int'(NREQ); i++) statCntQ[i] <= '0;
    end else if (handshake) begin
      for (int i = 0; i < int'(NREQ); i++) begin
        if (ownerQ == IDW'(i) && statCntQ[i] != '1) statCntQ[i] <= statCntQ[i] + 32'd1;
      end
    end
  end

  always_comb begin
    stat_cnt = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (stat_sel == IDW'(i)) stat_cnt = statCntQ[i];
    end
  end
`endif

endmodule

// File: tb/tb_adapter_bus_arbiter.sv
// Directed self-checking bench for adapter_bus_arbiter (NREQ=4, width=128).
module tb_adapter_bus_arbiter;

  logic         CLK = 1'b0;
  logic         nRST;
  logic [3:0]   req_pend;
  logic [3:0]   req_enq__ENA;
  logic [3:0]   req_enq__RDY;
  logic [511:0] req_enq_v;
  logic [63:0]  req_enq_size;
  logic         ad_enq__ENA;
  logic         ad_enq__RDY;
  logic [127:0] ad_enq_v;
  logic [15:0]  ad_enq_size;
  logic         ad_last_beat;
  logic [1:0]   owner;
  logic         owner_vld;
`ifdef ADAPTER_ARB_STATS_EN
  logic [1:0]   stat_sel;
  logic [31:0]  stat_cnt;
`endif

  int passCnt = 0;
  int totalCnt = 0;

  adapter_bus_arbiter #(.NREQ(4), .width(128)) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .req_pend     (req_pend),
    .req_enq__ENA (req_enq__ENA),
    .req_enq__RDY (req_enq__RDY),
    .req_enq_v    (req_enq_v),
    .req_enq_size (req_enq_size),
    .ad_enq__ENA  (ad_enq__ENA),
    .ad_enq__RDY  (ad_enq__RDY),
    .ad_enq_v     (ad_enq_v),
    .ad_enq_size  (ad_enq_size),
    .ad_last_beat (ad_last_beat),
    .owner        (owner),
    .owner_vld    (owner_vld)
`ifdef ADAPTER_ARB_STATS_EN
    ,
    .stat_sel     (stat_sel),
    .stat_cnt     (stat_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [127:0] dataOf(input int i);
    return {4{32'hA5A5_0000 + 32'(i)}};
  endfunction

  task automatic setSize(input int i, input logic [15:0] s);
    req_enq_size[i*16 +: 16] = s;
  endtask

  int expSeq [5] = '{0, 1, 2, 3, 0};

  initial begin
    nRST         = 1'b0;
    req_pend     = '0;
    req_enq__ENA = '0;
    req_enq_size = '0;
    ad_enq__RDY  = 1'b1;
    ad_last_beat = 1'b0;
    for (int i = 0; i < 4; i++) req_enq_v[i*128 +: 128] = dataOf(i);
`ifdef ADAPTER_ARB_STATS_EN
    stat_sel = '0;
`endif

    #2;
    chk("rst_vld", owner_vld, 0);
    chk("rst_owner", owner, 0);
    chk("rst_rdy", req_enq__RDY, 0);
    chk("rst_ad_ena", ad_enq__ENA, 0);
    chk("rst_ad_v", ad_enq_v, 0);
    chk("rst_ad_size", ad_enq_size, 0);
    #10 nRST = 1'b1;

    // T1: single requester, 3-beat message
    tick();
    req_pend = 4'b0010;
    setSize(1, 16'd96);
    #1 chk("t1_idle_rdy", req_enq__RDY, 0);
    tick();
    chk("t1_owner", owner, 1);
    chk("t1_vld", owner_vld, 1);
    chk("t1_rdy", req_enq__RDY, 4'b0010);
    chk("t1_ad_v_idle", ad_enq_v, 0);
    req_enq__ENA = 4'b0010;
    #1;
    chk("t1_ad_ena", ad_enq__ENA, 1);
    chk("t1_ad_v", ad_enq_v, dataOf(1));
    chk("t1_ad_size", ad_enq_size, 96);
    tick();
    req_enq__ENA = '0;
    req_pend     = '0;
    #1;
    chk("t1_drain_rdy", req_enq__RDY, 0);
    chk("t1_drain_ena", ad_enq__ENA, 0);
    tick();
    tick();
    chk("t1_drain_hold", owner_vld, 1);
    ad_last_beat = 1'b1;
    tick();
    chk("t1_idle", owner_vld, 0);
    tick();
    chk("t1_stray_last", owner_vld, 0);
    ad_last_beat = 1'b0;

    nRST = 1'b0;
    #1 chk("rst_pulse_vld", owner_vld, 0);
    nRST = 1'b1;

    // T2: round robin with all requesters pending
    req_pend = 4'b1111;
    for (int i = 0; i < 4; i++) setSize(i, 16'd32);
    for (int g = 0; g < 5; g++) begin
      tick();
      chk("t2_owner", owner, expSeq[g]);
      chk("t2_rdy", req_enq__RDY, 4'(1) << expSeq[g]);
      req_enq__ENA = 4'(1) << expSeq[g];
      #1 chk("t2_ad_v", ad_enq_v, dataOf(expSeq[g]));
      tick();
      req_enq__ENA = '0;
      ad_last_beat = 1'b1;
      #1;
      chk("t2_drain_rdy", req_enq__RDY, 0);
      chk("t2_drain_vld", owner_vld, 1);
      tick();
      ad_last_beat = 1'b0;
      #1 chk("t2_gap", owner_vld, 0);
    end

    // T3: backpressure in ISSUE
    tick();
    ad_enq__RDY  = 1'b0;
    req_enq__ENA = 4'b0010;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("t3_rdy", req_enq__RDY, 0);
      chk("t3_ena", ad_enq__ENA, 0);
      chk("t3_owner", owner, 1);
      chk("t3_vld", owner_vld, 1);
      tick();
    end
    ad_enq__RDY = 1'b1;
    #1;
    chk("t3_rdy_back", req_enq__RDY, 4'b0010);
    chk("t3_ena_back", ad_enq__ENA, 1);
    tick();
    req_enq__ENA = '0;
    req_pend     = '0;
    ad_last_beat = 1'b1;
    tick();
    ad_last_beat = 1'b0;

    // T4: zero-size message from requester 2
    req_pend = 4'b0100;
    setSize(2, 16'd0);
    tick();
    chk("t4_owner", owner, 2);
    req_enq__ENA = 4'b0100;
    #1;
    chk("t4_ena", ad_enq__ENA, 1);
    chk("t4_size", ad_enq_size, 0);
    tick();
    req_enq__ENA = '0;
    req_pend     = 4'b1111;
    #1 chk("t4_no_drain", owner_vld, 0);
    tick();
    chk("t4_rr", owner, 3);

    // T5: withdrawals, then reset mid-DRAIN
    req_pend = '0;
    #1 chk("t5_rdy_still", req_enq__RDY, 4'b1000);
    tick();
    chk("t5_wd_idle", owner_vld, 0);
    req_pend = 4'b0011;
    tick();
    chk("t5_owner0", owner, 0);
    req_pend = 4'b0010;
    tick();
    chk("t5_wd0_idle", owner_vld, 0);
    tick();
    chk("t5_next", owner, 1);
    setSize(1, 16'd64);
    req_enq__ENA = 4'b0010;
    tick();
    req_enq__ENA = '0;
    chk("t5_drain", owner_vld, 1);
    #1 nRST = 1'b0;
    #1;
    chk("t5_rst_vld", owner_vld, 0);
    chk("t5_rst_owner", owner, 0);
    chk("t5_rst_rdy", req_enq__RDY, 0);
    chk("t5_rst_ena", ad_enq__ENA, 0);

`ifdef ADAPTER_ARB_STATS_EN
    // T6: three zero-size messages from requester 1
    nRST = 1'b1;
    req_pend = 4'b0010;
    setSize(1, 16'd0);
    for (int m = 0; m < 3; m++) begin
      tick();
      req_enq__ENA = 4'b0010;
      tick();
      req_enq__ENA = '0;
    end
    req_pend = '0;
    stat_sel = 2'd1;
    #1 chk("t6_cnt1", stat_cnt, 3);
    stat_sel = 2'd0;
    #1 chk("t6_cnt0", stat_cnt, 0);
`endif

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
